// File: rtl/acondicionador_entradas.sv
// Input conditioner for board switches and buttons: two-flop synchronizer,
// per-input stability debounce, plus per-button press strobe and toggle flag.
module acondicionador_entradas #(
  parameter int N_SWITCH       = 16,
  parameter int N_BOTON        = 4,
  parameter int CUENTA_ESTABLE = 100000
) (
  input  logic                clk_pi,
  input  logic                rst_n_pi,
  input  logic [N_SWITCH-1:0] switch_pi,
  input  logic [N_BOTON-1:0]  boton_pi,
  output logic [N_SWITCH-1:0] switch_po,
  output logic [N_BOTON-1:0]  boton_po,
  output logic [N_BOTON-1:0]  pulso_po,
  output logic [N_BOTON-1:0]  conmutado_po
);

  localparam int N  = N_SWITCH + N_BOTON;
  localparam int CW = $clog2(CUENTA_ESTABLE + 1);
  localparam logic [CW-1:0] CUENTA_MAX = CW'(CUENTA_ESTABLE - 1);

  // Buttons occupy the upper bits so one debounce loop serves every input.
  logic [N-1:0]       sync1_q, sync2_q;
  logic [N-1:0]       estado_q, estado_d;
  logic [CW-1:0]      cuenta_q [N];
  logic [CW-1:0]      cuenta_d [N];
  logic [N_BOTON-1:0] pulso_q, pulso_d;
  logic [N_BOTON-1:0] conmutado_q, conmutado_d;
  logic [N_BOTON-1:0] subida;

  // NOTE: every variable gets a default before any condition, so no latch is inferred.
  always_comb begin
    estado_d = estado_q;
    for (int i = 0; i < N; i++) begin
      cuenta_d[i] = '0;
      if (sync2_q[i] != estado_q[i]) begin
        if (cuenta_q[i] == CUENTA_MAX) begin
          estado_d[i] = sync2_q[i];
        end else begin
          cuenta_d[i] = cuenta_q[i] + CW'(1);
        end
      end
    end

    subida      = estado_d[N-1:N_SWITCH] & ~estado_q[N-1:N_SWITCH];
    pulso_d     = subida;
    conmutado_d = conmutado_q ^ subida;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_pi) begin
    if (!rst_n_pi) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      estado_q    <= '0;
      pulso_q     <= '0;
      conmutado_q <= '0;
      // NOTE: the counter array is reset too, so a reset discards any partial count.
      for (int i = 0; i < N; i++) begin
        cuenta_q[i] <= '0;
      end
    end else begin
      sync1_q     <= {boton_pi, switch_pi};
      sync2_q     <= sync1_q;
      estado_q    <= estado_d;
      pulso_q     <= pulso_d;
      conmutado_q <= conmutado_d;
      for (int i = 0; i < N; i++) begin
        cuenta_q[i] <= cuenta_d[i];
      end
    end
  end

  assign switch_po    = estado_q[N_SWITCH-1:0];
  assign boton_po     = estado_q[N-1:N_SWITCH];
  assign pulso_po     = pulso_q;
  assign conmutado_po = conmutado_q;

endmodule

// File: tb/tb_acondicionador_entradas.sv
// Bench for acondicionador_entradas: directed scenarios plus random pin activity,
// compared every cycle against a sample-window reference model.
module tb_acondicionador_entradas;

  localparam int NS = 16;
  localparam int NB = 4;
  localparam int N  = NS + NB;
  localparam int C  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NS-1:0] sw_pins;
  logic [NB-1:0] bt_pins;
  logic [NS-1:0] switch_po;
  logic [NB-1:0] boton_po, pulso_po, conmutado_po;

  int n_checks = 0;
  int n_errors = 0;
  int pulses [NB];

  acondicionador_entradas #(
    .N_SWITCH      (NS),
    .N_BOTON       (NB),
    .CUENTA_ESTABLE(C)
  ) dut (
    .clk_pi      (clk),
    .rst_n_pi    (rst_n),
    .switch_pi   (sw_pins),
    .boton_pi    (bt_pins),
    .switch_po   (switch_po),
    .boton_po    (boton_po),
    .pulso_po    (pulso_po),
    .conmutado_po(conmutado_po)
  );

  always #5 clk = ~clk;

  // Reference: a pin reaches the debouncer two edges after it is sampled; the
  // debounced level flips once the last C delivered samples, all taken since the
  // previous flip or reset, disagree with it.
  logic [N-1:0]  m_d1, m_d2, m_state;
  logic [C-1:0]  m_win [N];
  int            m_seen [N];
  logic [NB-1:0] m_pulse, m_tog;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic [NS-1:0] sw, input logic [NB-1:0] bt, input logic rst);
    logic [N-1:0]  pins;
    logic [N-1:0]  old_state;
    logic [NB-1:0] rise;
    pins = {bt, sw};
    if (!rst) begin
      m_d1 = '0; m_d2 = '0; m_state = '0; m_pulse = '0; m_tog = '0;
      for (int i = 0; i < N; i++) begin
        m_win[i] = '0; m_seen[i] = 0;
      end
    end else begin
      old_state = m_state;
      for (int i = 0; i < N; i++) begin
        m_win[i] = {m_win[i][C-2:0], m_d2[i]};
        if (m_seen[i] < C) m_seen[i]++;
        if (m_seen[i] >= C && m_win[i] == {C{~old_state[i]}}) begin
          m_state[i] = ~old_state[i];
          m_seen[i]  = 0;
        end
      end
      m_d2 = m_d1;
      m_d1 = pins;
      rise    = m_state[N-1:NS] & ~old_state[N-1:NS];
      m_pulse = rise;
      m_tog   = m_tog ^ rise;
    end
  endtask

  // One clock: drive pins, advance the model on the edge, compare on the falling edge.
  task automatic step(input logic [NS-1:0] sw, input logic [NB-1:0] bt, input logic rst);
    sw_pins = sw;
    bt_pins = bt;
    rst_n   = rst;
    @(posedge clk);
    model_step(sw, bt, rst);
    @(negedge clk);
    check("switch_po", 32'(switch_po), 32'(m_state[NS-1:0]));
    check("boton_po", 32'(boton_po), 32'(m_state[N-1:NS]));
    check("pulso_po", 32'(pulso_po), 32'(m_pulse));
    check("conmutado_po", 32'(conmutado_po), 32'(m_tog));
    for (int b = 0; b < NB; b++) if (pulso_po[b] === 1'b1) pulses[b]++;
  endtask

  task automatic clear_pulses();
    for (int b = 0; b < NB; b++) pulses[b] = 0;
  endtask

  initial begin
    logic [NS-1:0] sw_r;
    logic [NB-1:0] bt_r;
    logic [5:0]    bounce;
    sw_pins = '0; bt_pins = '0; rst_n = 1'b0;
    clear_pulses();
    @(negedge clk);

    // Reset held with every pin high, then released.
    repeat (3) begin
      step('1, '1, 1'b0);
      check("rst_sw", 32'(switch_po), 32'h0);
      check("rst_bt", 32'(boton_po), 32'h0);
      check("rst_pl", 32'(pulso_po), 32'h0);
      check("rst_cm", 32'(conmutado_po), 32'h0);
    end
    for (int k = 1; k <= 6; k++) begin
      step('1, '1, 1'b1);
      if (k == 5) check("rel_bt_early", 32'(boton_po), 32'h0);
    end
    check("rel_sw", 32'(switch_po), 32'hFFFF);
    check("rel_bt", 32'(boton_po), 32'hF);
    check("rel_pl", 32'(pulso_po), 32'hF);
    check("rel_cm", 32'(conmutado_po), 32'hF);
    step('1, '1, 1'b1);
    check("rel_pl_off", 32'(pulso_po), 32'h0);
    check("rel_cm_hold", 32'(conmutado_po), 32'hF);

    // Clean press on button 0, from a fresh reset.
    step('0, '0, 1'b0);
    repeat (3) step('0, '0, 1'b1);
    clear_pulses();
    for (int k = 1; k <= 7; k++) begin
      step('0, 4'b0001, 1'b1);
      if (k == 5) check("press_early", 32'(boton_po[0]), 32'h0);
      if (k == 6) begin
        check("press_bt", 32'(boton_po[0]), 32'h1);
        check("press_pl", 32'(pulso_po), 32'h1);
        check("press_cm", 32'(conmutado_po[0]), 32'h1);
      end
      if (k == 7) check("press_pl_off", 32'(pulso_po[0]), 32'h0);
    end
    repeat (10) step('0, 4'b0000, 1'b1);
    repeat (10) step('0, 4'b0001, 1'b1);
    repeat (10) step('0, 4'b0000, 1'b1);
    check("press_cm_back", 32'(conmutado_po[0]), 32'h0);
    check("press_count", 32'(pulses[0]), 32'd2);

    // Bouncing button 1, then held.
    clear_pulses();
    bounce = 6'b101101;
    for (int k = 0; k < 6; k++) step('0, {2'b00, bounce[5-k], 1'b0}, 1'b1);
    repeat (4) step('0, 4'b0010, 1'b1);
    check("bounce_quiet", 32'(pulses[1]), 32'd0);
    repeat (10) step('0, 4'b0010, 1'b1);
    check("bounce_single", 32'(pulses[1]), 32'd1);
    check("bounce_bt", 32'(boton_po[1]), 32'h1);

    // All switches change together, then a short glitch on one of them.
    repeat (20) step(16'hA5A5, 4'b0010, 1'b1);
    check("sw_parallel", 32'(switch_po), 32'hA5A5);
    repeat (2) step(16'hA5AD, 4'b0010, 1'b1);
    repeat (10) begin
      step(16'hA5A5, 4'b0010, 1'b1);
      check("sw_glitch", 32'(switch_po), 32'hA5A5);
    end

    // Reset in the middle of a debounce on button 2.
    step('0, '0, 1'b0);
    repeat (3) step('0, '0, 1'b1);
    clear_pulses();
    repeat (4) step('0, 4'b0100, 1'b1);
    step('0, 4'b0100, 1'b0);
    check("mid_rst_bt", 32'(boton_po), 32'h0);
    check("mid_rst_cm", 32'(conmutado_po), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      step('0, 4'b0100, 1'b1);
      if (k == 5) check("mid_rst_early", 32'(boton_po[2]), 32'h0);
    end
    check("mid_rst_bt2", 32'(boton_po[2]), 32'h1);
    check("mid_rst_pl", 32'(pulso_po), 32'h4);
    repeat (10) step('0, 4'b0100, 1'b1);
    check("mid_rst_count", 32'(pulses[2]), 32'd1);

    // Release of button 3 yields no pulse and keeps its toggle.
    repeat (10) step('0, 4'b1100, 1'b1);
    check("rls_press", 32'(pulses[3]), 32'd1);
    repeat (10) step('0, 4'b0100, 1'b1);
    check("rls_bt", 32'(boton_po[3]), 32'h0);
    check("rls_count", 32'(pulses[3]), 32'd1);
    check("rls_cm", 32'(conmutado_po[3]), 32'h1);

    // Random pin activity with occasional resets.
    sw_r = '0;
    bt_r = '0;
    for (int k = 0; k < 2000; k++) begin
      for (int i = 0; i < NS; i++) if ($urandom_range(7) == 0) sw_r[i] = ~sw_r[i];
      for (int i = 0; i < NB; i++) if ($urandom_range(7) == 0) bt_r[i] = ~bt_r[i];
      step(sw_r, bt_r, ($urandom_range(299) == 0) ? 1'b0 : 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/acondicionador_entradas.md
Name: acondicionador_entradas

Overview:
- Input-side conditioner for the board's user controls: takes raw asynchronous switch_pi[15:0] and boton_pi[3:0] pins and delivers synchronized, debounced levels plus per-button press pulses and toggle flags.
- Sits between the board pins and the switch/LED masking logic; its outputs replace raw pins wherever a clean level or single-event press is required.

Parameters:
- N_SWITCH, 16, number of switch inputs conditioned
- N_BOTON, 4, number of button inputs conditioned
- CUENTA_ESTABLE, 100000, consecutive cycles a synchronized input must differ from its debounced state before that state updates (10 ms at 10 MHz); legal range >= 2
- Counter width per input = $clog2(CUENTA_ESTABLE+1)

Ports:
- clk_pi  input  1  system clock, single clock domain
- rst_n_pi  input  1  synchronous reset, active-low
- switch_pi  input  N_SWITCH  raw asynchronous switch levels
- boton_pi  input  N_BOTON  raw asynchronous button levels, 1 = pressed
- switch_po  output  N_SWITCH  debounced switch levels
- boton_po  output  N_BOTON  debounced button levels
- pulso_po  output  N_BOTON  one-cycle strobe per button on debounced press (0->1)
- conmutado_po  output  N_BOTON  per-button toggle flag, inverts on each press

Behaviour:
- Reset: rst_n_pi sampled low at a clk_pi rising edge clears all sync flops, counters, switch_po, boton_po, pulso_po, conmutado_po to 0 on that edge. Reset asserted mid-debounce discards partial counts; no output changes other than clearing.
- Synchronizer: each input passes through 2 flops (sync1, sync2); all downstream logic uses sync2 only.
- Debounce, identical per input (switches and buttons), registered state = corresponding bit of switch_po/boton_po:
  - sync2 == state: counter <= 0.
  - sync2 != state and counter < CUENTA_ESTABLE-1: counter <= counter+1.
  - sync2 != state and counter == CUENTA_ESTABLE-1: state <= sync2, counter <= 0.
  - Any glitch back to the state value before the count completes restarts the count from 0.
- Latency: a clean pin change captured at edge t appears on the debounced output at edge t+1+CUENTA_ESTABLE (2 sync stages + CUENTA_ESTABLE mismatch cycles, first mismatch cycle overlapping sync2 load).
- Press pulse: pulso_po[i] is registered and is 1 for exactly the one cycle after the edge on which boton_po[i] goes 0->1, else 0. Release (1->0) produces no pulse.
- Toggle: conmutado_po[i] inverts on the same edge that pulso_po[i] is asserted.
- Independence: every input has its own counter; simultaneous changes on several inputs debounce in parallel with no interaction.
- Held inputs: a button held indefinitely produces exactly one pulse; no auto-repeat.
- Counter never exceeds CUENTA_ESTABLE-1; no wrap-around.

Test Plan (CUENTA_ESTABLE=4 in simulation):
- Reset: hold rst_n_pi=0 for 3 cycles with all inputs at 1 -> all outputs 0 throughout; after release, switch_po=16'hFFFF and boton_po=4'hF after 5 cycles, pulso_po asserts 4'hF for exactly one cycle, then conmutado_po=4'hF.
- Clean press: boton_pi[0] 0->1 at edge t -> boton_po[0]=1 at edge t+5; pulso_po[0]=1 only during the following cycle; conmutado_po[0] 0->1; second press-release cycle returns conmutado_po[0] to 0.
- Bounce: boton_pi[1] pattern 1,0,1,1,0,1 one cycle each, then held 1 -> no pulso_po[1] during the bounce; single pulse once 4 consecutive stable synchronized 1s accumulate.
- Parallel switches: switch_pi 16'h0000 -> 16'hA5A5 in one cycle -> switch_po goes 16'hA5A5 on a single edge; a 2-cycle glitch on switch_pi[3] afterwards leaves switch_po unchanged.
- Reset mid-operation: press boton_pi[2], assert rst_n_pi for 1 cycle after 2 stable synchronized cycles -> outputs cleared, count restarts; boton_po[2] rises 5 cycles after reset release with one pulse.
- Release: debounced boton_po[3] 1->0 -> no pulso_po[3], conmutado_po[3] unchanged.
